// File: rtl/dmem_arbiter.sv
// Two-port (cpu/host) arbiter for the single-port data memory: IDLE -> ISSUE -> WAIT -> RESP.
// Optional perf counters (cpu_wait_cnt, host_grant_cnt) are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
  parameter  int DATA_W  = 64,
  parameter  int DEPTH   = 1024,
  parameter  int MEM_LAT = 1,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [63:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [63:0]       host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              host_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       cpu_wait_cnt,
  output logic [31:0]       host_grant_cnt
`endif
);

  // Handshake: a requester holds req/we/addr/wdata stable until its one-cycle ack,
  // and only IDLE looks at requests; anything seen elsewhere waits for the next IDLE.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic        PORT_CPU  = 1'b0;
  localparam logic        PORT_HOST = 1'b1;
  localparam logic [1:0]  LAT_M1    = 2'(MEM_LAT - 1);
  localparam logic [60:0] DEPTH_W   = 61'(DEPTH);

  state_t              state_q, state_d;
  logic                last_win_q, last_win_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [IDX_W-1:0]    mem_idx_q, mem_idx_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic                host_ack_q, host_ack_d, host_err_q, host_err_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;

  logic                win_host, win_bad, go_resp, resp_err;
  logic [63:0]         win_addr;
  logic [DATA_W-1:0]   resp_data;

  always_comb begin
    win_host     = (cpu_req && host_req) ? (last_win_q == PORT_CPU) : host_req;
    win_addr     = win_host ? host_addr : cpu_addr;
    win_bad      = (win_addr[2:0] != 3'd0) || (win_addr[63:3] >= DEPTH_W);
    state_d      = state_q;
    last_win_d   = last_win_q;
    port_d       = port_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mem_idx_d    = mem_idx_q;
    mem_wdata_d  = mem_wdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_rdata_d  = '0;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    host_rdata_d = '0;
    go_resp      = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req || host_req) begin
          last_win_d  = win_host;
          port_d      = win_host;
          we_d        = win_host ? host_we : cpu_we;
          mem_idx_d   = win_addr[IDX_W+2:3];
          mem_wdata_d = win_host ? host_wdata : cpu_wdata;
          if (win_bad) begin
            state_d  = RESP;
            go_resp  = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d  = ISSUE;
            mem_en_d = 1'b1;
            mem_we_d = we_d;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_M1;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d   = RESP;
          go_resp   = 1'b1;
          resp_data = we_q ? '0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The response registers are loaded on the edge that enters RESP.
    if (go_resp) begin
      if (port_d == PORT_HOST) begin
        host_ack_d   = 1'b1;
        host_err_d   = resp_err;
        host_rdata_d = resp_data;
      end else begin
        cpu_ack_d   = 1'b1;
        cpu_err_d   = resp_err;
        cpu_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_win_q   <= PORT_HOST;
      port_q       <= PORT_CPU;
      we_q         <= 1'b0;
      cnt_q        <= 2'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_idx_q    <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_win_q   <= last_win_d;
      port_q       <= port_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_idx_q    <= mem_idx_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Gated by reset so the stall request is also quiet while reset is held.
  assign cpu_stall  = reset & cpu_req & ~cpu_ack_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_ack   = host_ack_q;
  assign host_err   = host_err_q;
  assign host_rdata = host_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_idx    = mem_idx_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cpu_wait_cnt_q, cpu_wait_cnt_d, host_grant_cnt_q, host_grant_cnt_d;

  always_comb begin
    cpu_wait_cnt_d   = cpu_wait_cnt_q;
    host_grant_cnt_d = host_grant_cnt_q;
    if (cpu_stall && (cpu_wait_cnt_q != 32'hFFFF_FFFF))
      cpu_wait_cnt_d = cpu_wait_cnt_q + 32'd1;
    if ((state_q == IDLE) && win_host && (host_grant_cnt_q != 32'hFFFF_FFFF))
      host_grant_cnt_d = host_grant_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_wait_cnt_q   <= 32'd0;
      host_grant_cnt_q <= 32'd0;
    end else begin
      cpu_wait_cnt_q   <= cpu_wait_cnt_d;
      host_grant_cnt_q <= host_grant_cnt_d;
    end
  end

  assign cpu_wait_cnt   = cpu_wait_cnt_q;
  assign host_grant_cnt = host_grant_cnt_q;
`endif

endmodule
